steak_order_judge: RTL

Consumer side of the steak doneness interface. It issues a customer order for a target doneness and watches the 3-bit doneness code (0 non-existent, 1 raw, 2 rare, 3 medium-rare, 4 medium, 5 medium-well, 6 well-done, 7 burnt). When the player serves, it grades the served doneness against the order, accumulates score, and pulses a clear back to the steak side. It sits between the steak doneness FSM and the score/HEX display logic.

---
 rtl/steak_order_judge.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/steak_order_judge.sv
// Customer-side judge for steak doneness: issues orders, grades serves, keeps score.
// Optional STEAK_JUDGE_STREAK_EN adds a perfect-streak bonus (+5 on third perfect).
module steak_order_judge #(
  parameter int SCORE_W        = 8,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               new_order,
  input  logic               serve,
  input  logic [2:0]         steak_state,
  output logic [2:0]         order_state,
  output logic               order_active,
  output logic               result_valid,
  output logic [1:0]         result_code,
  output logic [SCORE_W-1:0] score,
  output logic               clear_steak
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = SCORE_W + 3;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_JUDGE,
    S_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         order_q, order_d;
  logic [2:0]         served_q, served_d;
  logic               valid_q, valid_d;
  logic [1:0]         code_q, code_d;
  logic               clear_q, clear_d;
  logic [SCORE_W-1:0] score_q, score_d;
`ifdef STEAK_JUDGE_STREAK_EN
  logic [1:0]         streak_q, streak_d;
  logic [1:0]         streak_nx;
`endif

  logic [2:0]    v;
  logic [2:0]    order_map;
  logic [3:0]    diff;
  logic [1:0]    j_code;
  logic [2:0]    j_add;
  logic [AW-1:0] sum;

  // Order mapping folds 5..7 onto 0..2 so orders land in 2..6
  always_comb begin
    v         = lfsr_q[2:0];
    order_map = (v >= 3'd5) ? (v - 3'd5 + 3'd2) : (v + 3'd2);
  end

  always_comb begin
    diff = ({1'b0, served_q} >= {1'b0, order_q})
         ? ({1'b0, served_q} - {1'b0, order_q})
         : ({1'b0, order_q} - {1'b0, served_q});
    j_code = 2'd2;
    j_add  = 3'd0;
`ifdef STEAK_JUDGE_STREAK_EN
    streak_nx = 2'd0;
`endif
    if (diff == 4'd0) begin
      j_code = 2'd0;
      j_add  = 3'd3;
`ifdef STEAK_JUDGE_STREAK_EN
      if (streak_q == 2'd2) begin
        j_add     = 3'd5;
        streak_nx = 2'd0;
      end else begin
        streak_nx = streak_q + 2'd1;
      end
`endif
    end else if (diff == 4'd1 && served_q != 3'd7) begin
      j_code = 2'd1;
      j_add  = 3'd1;
    end
    sum = AW'(score_q) + AW'(j_add);
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    timer_d  = timer_q;
    order_d  = order_q;
    served_d = served_q;
    valid_d  = 1'b0;
    code_d   = code_q;
    clear_d  = 1'b0;
    score_d  = score_q;
`ifdef STEAK_JUDGE_STREAK_EN
    streak_d = streak_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (new_order) begin
          order_d = order_map;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (serve && steak_state != 3'd0) begin
          served_d = steak_state;
          state_d  = S_JUDGE;
        end else if (timer_q == T_LAST) begin
          state_d = S_REPORT;
          valid_d = 1'b1;
          code_d  = 2'd3;
          score_d = (score_q == '0) ? '0 : score_q - SCORE_W'(1);
`ifdef STEAK_JUDGE_STREAK_EN
          streak_d = 2'd0;
`endif
        end
      end
      S_JUDGE: begin
        state_d = S_REPORT;
        valid_d = 1'b1;
        clear_d = 1'b1;
        code_d  = j_code;
        score_d = (sum > AW'(S_MAX)) ? S_MAX : sum[SCORE_W-1:0];
`ifdef STEAK_JUDGE_STREAK_EN
        streak_d = streak_nx;
`endif
      end
      S_REPORT: begin
        order_d = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 8'hA5;
      timer_q  <= '0;
      order_q  <= 3'd0;
      served_q <= 3'd0;
      valid_q  <= 1'b0;
      code_q   <= 2'd0;
      clear_q  <= 1'b0;
      score_q  <= '0;
`ifdef STEAK_JUDGE_STREAK_EN
      streak_q <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      order_q  <= order_d;
      served_q <= served_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      clear_q  <= clear_d;
      score_q  <= score_d;
`ifdef STEAK_JUDGE_STREAK_EN
      streak_q <= streak_d;
`endif
    end
  end

  assign order_state  = order_q;
  assign order_active = (state_q == S_WAIT);
  assign result_valid = valid_q;
  assign result_code  = code_q;
  assign score        = score_q;
  assign clear_steak  = clear_q;

endmodule
